// File: rtl/signal_buffer_ram.sv
// Dual-port 16-bit word buffer with byte enables and a zero-fill sweep after reset.
// Port A wins same-address write collisions; B is held for exactly one cycle.
module signal_buffer_ram #(
    parameter int DEPTH          = 8192,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:0] address_a,
    input  logic        chipselect_a,
    input  logic        read_a,
    input  logic        write_a,
    input  logic [15:0] writedata_a,
    input  logic [1:0]  byteenable_a,
    output logic [15:0] readdata_a,
    output logic        waitrequest_a,
    input  logic [12:0] address_b,
    input  logic        chipselect_b,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [15:0] writedata_b,
    input  logic [1:0]  byteenable_b,
    output logic [15:0] readdata_b,
    output logic        waitrequest_b,
    output logic        busy
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [13:0] DEPTH_W = 14'(DEPTH);
    localparam logic [12:0] LAST    = 13'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] clr_cnt_q, clr_cnt_d;
    logic        stall_b_q, stall_b_d;
    logic [15:0] rdata_a_q, rdata_a_d;
    logic [15:0] rdata_b_q, rdata_b_d;

    logic [15:0] mem [DEPTH];

    logic run;
    logic collide;
    logic acc_a, acc_b;
    logic we_a, we_b;
    logic re_a, re_b;
    logic ok_a, ok_b;

    always_comb begin
        run     = (state_q == RUN);
        ok_a    = ({1'b0, address_a} < DEPTH_W);
        ok_b    = ({1'b0, address_b} < DEPTH_W);
        collide = run & chipselect_a & write_a
                & chipselect_b & write_b
                & (address_a == address_b);

        waitrequest_a = reset | ~run;
        waitrequest_b = reset | ~run | (collide & ~stall_b_q);

        acc_a = chipselect_a & (read_a | write_a) & ~waitrequest_a;
        acc_b = chipselect_b & (read_b | write_b) & ~waitrequest_b;
        // a combined read+write is a write only
        we_a  = acc_a & write_a;
        we_b  = acc_b & write_b;
        re_a  = acc_a & read_a & ~write_a;
        re_b  = acc_b & read_b & ~write_b;

        busy       = reset ? CLEAR_ON_RESET : ~run;
        readdata_a = reset ? 16'h0000 : rdata_a_q;
        readdata_b = reset ? 16'h0000 : rdata_b_q;
    end

    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re_a) begin
            rdata_a_d = ok_a ? mem[address_a[AW-1:0]] : 16'h0000;
        end
        if (re_b) begin
            rdata_b_d = ok_b ? mem[address_b[AW-1:0]] : 16'h0000;
        end
        stall_b_d = collide & ~stall_b_q;
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            if (clr_cnt_q == LAST) begin
                state_d   = RUN;
                clr_cnt_d = 13'd0;
            end else begin
                clr_cnt_d = clr_cnt_q + 13'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt_q <= 13'd0;
            stall_b_q <= 1'b0;
            rdata_a_q <= 16'h0000;
            rdata_b_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            stall_b_q <= stall_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    // B is applied after A so a released collision write from B lands last
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[clr_cnt_q[AW-1:0]] <= 16'h0000;
            end else begin
                if (we_a && ok_a) begin
                    if (byteenable_a[0]) mem[address_a[AW-1:0]][7:0]  <= writedata_a[7:0];
                    if (byteenable_a[1]) mem[address_a[AW-1:0]][15:8] <= writedata_a[15:8];
                end
                if (we_b && ok_b) begin
                    if (byteenable_b[0]) mem[address_b[AW-1:0]][7:0]  <= writedata_b[7:0];
                    if (byteenable_b[1]) mem[address_b[AW-1:0]][15:8] <= writedata_b[15:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_signal_buffer_ram.sv
// Directed bench for signal_buffer_ram: a DEPTH=256 cleared instance plus a
// full-depth no-clear instance sharing the same stimulus.
module tb_signal_buffer_ram;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] addr_a, addr_b;
    logic        cs_a, cs_b, rd_a, rd_b, wr_a, wr_b;
    logic [15:0] wd_a, wd_b;
    logic [1:0]  be_a, be_b;

    logic [15:0] rda, rdb, rda2, rdb2;
    logic        wa, wb, wa2, wb2, busy, busy2;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clock = ~clock;

    signal_buffer_ram #(.DEPTH(256), .CLEAR_ON_RESET(1'b1)) dut (
        .clock(clock), .reset(reset),
        .address_a(addr_a), .chipselect_a(cs_a), .read_a(rd_a), .write_a(wr_a),
        .writedata_a(wd_a), .byteenable_a(be_a), .readdata_a(rda), .waitrequest_a(wa),
        .address_b(addr_b), .chipselect_b(cs_b), .read_b(rd_b), .write_b(wr_b),
        .writedata_b(wd_b), .byteenable_b(be_b), .readdata_b(rdb), .waitrequest_b(wb),
        .busy(busy)
    );

    signal_buffer_ram #(.DEPTH(8192), .CLEAR_ON_RESET(1'b0)) dut_big (
        .clock(clock), .reset(reset),
        .address_a(addr_a), .chipselect_a(cs_a), .read_a(rd_a), .write_a(wr_a),
        .writedata_a(wd_a), .byteenable_a(be_a), .readdata_a(rda2), .waitrequest_a(wa2),
        .address_b(addr_b), .chipselect_b(cs_b), .read_b(rd_b), .write_b(wr_b),
        .writedata_b(wd_b), .byteenable_b(be_b), .readdata_b(rdb2), .waitrequest_b(wb2),
        .busy(busy2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_a();
        cs_a = 0; rd_a = 0; wr_a = 0; addr_a = '0; wd_a = '0; be_a = 2'b00;
    endtask

    task automatic idle_b();
        cs_b = 0; rd_b = 0; wr_b = 0; addr_b = '0; wd_b = '0; be_b = 2'b00;
    endtask

    task automatic put_a(input logic r, input logic w, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        cs_a = 1; rd_a = r; wr_a = w; addr_a = a; wd_a = d; be_a = be;
    endtask

    task automatic put_b(input logic r, input logic w, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        cs_b = 1; rd_b = r; wr_b = w; addr_b = a; wd_b = d; be_b = be;
    endtask

    task automatic test_reset();
        reset = 1; idle_a(); idle_b();
        tick(); tick();
        checks++; if (rda !== 16'h0) begin errors++; $display("FAIL rst_rda: got %h want 0000", rda); end
        checks++; if (rdb !== 16'h0) begin errors++; $display("FAIL rst_rdb: got %h want 0000", rdb); end
        checks++; if (wa !== 1'b1) begin errors++; $display("FAIL rst_wa: got %b want 1", wa); end
        checks++; if (wb !== 1'b1) begin errors++; $display("FAIL rst_wb: got %b want 1", wb); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy_noclr: got %b want 0", busy2); end
        reset = 0;
        #1;
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        checks++; if (n !== 256) begin errors++; $display("FAIL clear_len: got %0d want 256", n); end
        checks++; if (wa2 !== 1'b0) begin errors++; $display("FAIL noclr_wa: got %b want 0", wa2); end
        put_a(1, 0, 13'h0FF, 16'h0, 2'b00);
        tick(); idle_a();
        checks++; if (rda !== 16'h0000) begin errors++; $display("FAIL clr_rd_ff: got %h want 0000", rda); end
    endtask

    task automatic test_byteenable();
        put_a(0, 1, 13'd5, 16'hAAAA, 2'b11); tick();
        put_a(0, 1, 13'd5, 16'h1234, 2'b10); tick();
        put_a(1, 0, 13'd5, 16'h0, 2'b00); tick();
        checks++; if (rda !== 16'h12AA) begin errors++; $display("FAIL be_hi: got %h want 12AA", rda); end
        put_a(0, 1, 13'd5, 16'hFFFF, 2'b00); tick();
        put_a(1, 0, 13'd5, 16'h0, 2'b00); tick();
        idle_a();
        checks++; if (rda !== 16'h12AA) begin errors++; $display("FAIL be_none: got %h want 12AA", rda); end
    endtask

    task automatic test_cross_port();
        put_a(0, 1, 13'h123, 16'hBEEF, 2'b11); tick();
        idle_a(); put_b(1, 0, 13'h123, 16'h0, 2'b00); tick();
        checks++; if (rdb2 !== 16'hBEEF) begin errors++; $display("FAIL xport_big: got %h want BEEF", rdb2); end
        checks++; if (rdb !== 16'h0000) begin errors++; $display("FAIL xport_oor: got %h want 0000", rdb); end
        idle_b();
        put_a(0, 1, 13'h023, 16'hBEEF, 2'b11); tick();
        idle_a(); put_b(1, 0, 13'h023, 16'h0, 2'b00); tick();
        idle_b();
        checks++; if (rdb !== 16'hBEEF) begin errors++; $display("FAIL xport: got %h want BEEF", rdb); end
    endtask

    task automatic test_read_before_write();
        put_a(0, 1, 13'd9, 16'h5555, 2'b11);
        put_b(1, 0, 13'd9, 16'h0, 2'b00);
        tick();
        checks++; if (rdb !== 16'h0000) begin errors++; $display("FAIL rbw_old: got %h want 0000", rdb); end
        idle_a(); tick();
        checks++; if (rdb !== 16'h5555) begin errors++; $display("FAIL rbw_new: got %h want 5555", rdb); end
        idle_b(); tick(); tick();
        checks++; if (rdb !== 16'h5555) begin errors++; $display("FAIL rd_hold: got %h want 5555", rdb); end
    endtask

    task automatic test_rw_same_port();
        put_b(1, 1, 13'd9, 16'h7777, 2'b11); tick();
        checks++; if (rdb !== 16'h5555) begin errors++; $display("FAIL rw_noupd: got %h want 5555", rdb); end
        put_b(1, 0, 13'd9, 16'h0, 2'b00); tick();
        idle_b();
        checks++; if (rdb !== 16'h7777) begin errors++; $display("FAIL wr_then_rd: got %h want 7777", rdb); end
    endtask

    task automatic test_collision();
        put_a(0, 1, 13'd7, 16'h1111, 2'b11);
        put_b(0, 1, 13'd7, 16'h2222, 2'b11);
        #1;
        checks++; if (wb !== 1'b1) begin errors++; $display("FAIL col_wb: got %b want 1", wb); end
        checks++; if (wa !== 1'b0) begin errors++; $display("FAIL col_wa: got %b want 0", wa); end
        tick(); idle_a(); #1;
        checks++; if (wb !== 1'b0) begin errors++; $display("FAIL col_release: got %b want 0", wb); end
        tick(); idle_b();
        put_a(1, 0, 13'd7, 16'h0, 2'b00); tick(); idle_a();
        checks++; if (rda !== 16'h2222) begin errors++; $display("FAIL col_final: got %h want 2222", rda); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            put_a(0, 1, 13'(10 + i), 16'h0A00 + 16'(i), 2'b11);
            put_b(0, 1, 13'(20 + i), 16'h0B00 + 16'(i), 2'b11);
            #1;
            checks++; if ({wa, wb} !== 2'b00) begin errors++; $display("FAIL b2b_wait: got %b want 00", {wa, wb}); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            put_a(1, 0, 13'(20 + i), 16'h0, 2'b00);
            put_b(1, 0, 13'(10 + i), 16'h0, 2'b00);
            tick();
            checks++; if (rda !== 16'h0B00 + 16'(i)) begin errors++; $display("FAIL b2b_rda%0d: got %h want %h", i, rda, 16'h0B00 + 16'(i)); end
            checks++; if (rdb !== 16'h0A00 + 16'(i)) begin errors++; $display("FAIL b2b_rdb%0d: got %h want %h", i, rdb, 16'h0A00 + 16'(i)); end
        end
        idle_a(); idle_b();
    endtask

    task automatic test_out_of_range();
        put_a(0, 1, 13'h0F0, 16'h0F0F, 2'b11); tick();
        put_a(0, 1, 13'h1F0, 16'h9999, 2'b11); tick();
        put_a(1, 0, 13'h1F0, 16'h0, 2'b00); tick();
        checks++; if (rda !== 16'h0000) begin errors++; $display("FAIL oor_rd: got %h want 0000", rda); end
        put_a(1, 0, 13'h0F0, 16'h0, 2'b00); tick();
        idle_a();
        checks++; if (rda !== 16'h0F0F) begin errors++; $display("FAIL oor_alias: got %h want 0F0F", rda); end
    endtask

    task automatic test_mid_clear_reset();
        reset = 1; tick();
        reset = 0;
        repeat (100) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset = 1; tick();
        reset = 0;
        put_a(0, 1, 13'd3, 16'h4444, 2'b11);
        #1;
        checks++; if (wa !== 1'b1) begin errors++; $display("FAIL clr_wa: got %b want 1", wa); end
        n = 0;
        tick(); n++;
        idle_a();
        while (busy && n < 400) begin tick(); n++; end
        checks++; if (n !== 256) begin errors++; $display("FAIL restart_len: got %0d want 256", n); end
        put_a(1, 0, 13'd3, 16'h0, 2'b00);
        put_b(1, 0, 13'd5, 16'h0, 2'b00);
        tick(); idle_a(); idle_b();
        checks++; if (rda !== 16'h0000) begin errors++; $display("FAIL clr_ignore: got %h want 0000", rda); end
        checks++; if (rdb !== 16'h0000) begin errors++; $display("FAIL refill: got %h want 0000", rdb); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_a(); idle_b();
        test_reset();
        test_byteenable();
        test_cross_port();
        test_read_before_write();
        test_rw_same_port();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_mid_clear_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
